// File: rtl/oled_pkg.sv
// Shared definitions for the OLED display path: SSD1306 opcodes, D/C
// encodings, the SPI word layout and the refresh state encoding.
package oled_pkg;

    localparam int SPI_W = 10;

    // SSD1306 addressing opcodes (page address and column nibble setters)
    localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO   = 8'h00;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;

    // D/C line: low selects the command register, high selects display RAM
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD_PAGE,
        S_CMD_COLL,
        S_CMD_COLH,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_WAIT,
        S_FIN
    } refresh_state_t;

    // Pack one SPI word: the top bit is reserved and always zero
    function automatic logic [SPI_W-1:0] spi_word(input logic dc, input logic [7:0] payload);
        return {1'b0, dc, payload};
    endfunction

endpackage

// File: rtl/oled_refresh.sv
// Display refresh engine: streams PAGES x COLS framebuffer bytes to the
// SSD1306, preceded on every page by page-address and column-reset commands.
// Owns the shared SPI word interface only while BUSY is high.
module oled_refresh
    import oled_pkg::*;
#(
    parameter int PAGES      = 8,
    parameter int COLS       = 128,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic [9:0]       fb_addr,
    input  logic [7:0]       fb_rdata,
    output logic             spi_start,
    input  logic             spi_done,
    output logic [SPI_W-1:0] spi_data
);

    localparam logic [2:0] LAST_PAGE = 3'(PAGES - 1);
    localparam logic [6:0] LAST_COL  = 7'(COLS - 1);

    refresh_state_t state;
    refresh_state_t ret_state;   // where WAIT goes on spi_done; S_SEND marks "after a data byte"
    logic [2:0]     page;
    logic [6:0]     col;
    logic [9:0]     row_base;

    // Framebuffer offset of the current page; a full 128-column row is a plain shift
    always_comb begin
        if (COLS == 128) begin
            row_base = {page, 7'b0};
        end else begin
            row_base = 10'(int'(page) * COLS);
        end
    end

    // Refresh sequencer with registered SPI, framebuffer and handshake outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: every state register and output is reset so the block re-enters
        // IDLE cleanly even when RST_N drops in the middle of a frame.
        if (!RST_N) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            page      <= '0;
            col       <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            spi_start <= 1'b0;
            spi_data  <= '0;
            fb_addr   <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle; the states below raise
            // them for exactly one clock with non-blocking updates.
            spi_start <= 1'b0;
            DONE      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        page  <= '0;
                        BUSY  <= 1'b1;
                        state <= S_CMD_PAGE;
                    end
                end
                S_CMD_PAGE: begin
                    spi_data  <= spi_word(DC_CMD, CMD_SET_PAGE | {5'b0, page});
                    spi_start <= 1'b1;
                    ret_state <= S_CMD_COLL;
                    state     <= S_WAIT;
                end
                S_CMD_COLL: begin
                    spi_data  <= spi_word(DC_CMD, CMD_COL_LO);
                    spi_start <= 1'b1;
                    ret_state <= S_CMD_COLH;
                    state     <= S_WAIT;
                end
                S_CMD_COLH: begin
                    spi_data  <= spi_word(DC_CMD, CMD_COL_HI);
                    spi_start <= 1'b1;
                    ret_state <= S_FETCH;
                    col       <= '0;
                    state     <= S_WAIT;
                end
                S_FETCH: begin
                    fb_addr <= row_base + {3'b0, col};
                    state   <= S_LATCH;
                end
                // The RAM registers fb_addr on this edge; its data is valid in SEND
                S_LATCH: begin
                    state <= S_SEND;
                end
                S_SEND: begin
                    spi_data  <= spi_word(DC_DATA, fb_rdata);
                    spi_start <= 1'b1;
                    ret_state <= S_SEND;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_done) begin
                        if (ret_state != S_SEND) begin
                            state <= ret_state;
                        end else if (col != LAST_COL) begin
                            col   <= col + 7'd1;
                            state <= S_FETCH;
                        end else if (page != LAST_PAGE) begin
                            page  <= page + 3'd1;
                            state <= S_CMD_PAGE;
                        end else begin
                            DONE  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    if (CONTINUOUS && START) begin
                        page  <= '0;
                        state <= S_CMD_PAGE;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_refresh.sv
// Directed bench for oled_refresh: a default 8x128 instance and a small
// continuous 2x4 instance, each with a synchronous framebuffer holding
// addr[7:0] and an SPI responder that raises spi_done a set delay after spi_start.
module tb_oled_refresh;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       start_s     [2];
    logic       busy_s      [2];
    logic       done_s      [2];
    logic       spi_start_s [2];
    logic       spi_done_s  [2];
    logic [9:0] fb_addr_s   [2];
    logic [9:0] spi_data_s  [2];
    logic [7:0] fb_rdata_s  [2];

    int vectors     = 0;
    int miscompares = 0;

    // Responder / monitor state
    int         cnt          [2] = '{0, 0};
    int         delay        [2] = '{4, 4};
    int         done_cnt     [2] = '{0, 0};
    int         extra_starts [2] = '{0, 0};
    int         unstable     [2] = '{0, 0};
    int         done_no_busy [2] = '{0, 0};
    bit         real_prev    [2] = '{0, 0};
    logic [9:0] last_word    [2];
    bit         inject = 1'b0;
    logic [9:0] wq0[$];
    logic [9:0] wq1[$];

    always #5 CLK = ~CLK;

    oled_refresh dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (start_s[0]),
        .BUSY      (busy_s[0]),
        .DONE      (done_s[0]),
        .fb_addr   (fb_addr_s[0]),
        .fb_rdata  (fb_rdata_s[0]),
        .spi_start (spi_start_s[0]),
        .spi_done  (spi_done_s[0]),
        .spi_data  (spi_data_s[0])
    );

    oled_refresh #(.PAGES(2), .COLS(4), .CONTINUOUS(1'b1)) dut_c (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (start_s[1]),
        .BUSY      (busy_s[1]),
        .DONE      (done_s[1]),
        .fb_addr   (fb_addr_s[1]),
        .fb_rdata  (fb_rdata_s[1]),
        .spi_start (spi_start_s[1]),
        .spi_done  (spi_done_s[1]),
        .spi_data  (spi_data_s[1])
    );

    // Synchronous framebuffers: contents equal the low address byte
    always @(posedge CLK) begin
        fb_rdata_s[0] <= fb_addr_s[0][7:0];
        fb_rdata_s[1] <= fb_addr_s[1][7:0];
    end

    // SPI responder and protocol monitor, evaluated on the falling edge
    initial begin
        spi_done_s[0] = 1'b0;
        spi_done_s[1] = 1'b0;
        forever begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                bit was_real;
                was_real       = real_prev[k];
                real_prev[k]   = 1'b0;
                spi_done_s[k]  = 1'b0;
                if (!RST_N) cnt[k] = 0;
                if (done_s[k]) begin
                    done_cnt[k]++;
                    if (!busy_s[k]) done_no_busy[k]++;
                end
                if (cnt[k] > 0) begin
                    if (spi_start_s[k]) extra_starts[k]++;
                    if (spi_data_s[k] !== last_word[k]) unstable[k]++;
                    cnt[k]--;
                    if (cnt[k] == 0) begin
                        spi_done_s[k] = 1'b1;
                        real_prev[k]  = 1'b1;
                    end
                end else if (spi_start_s[k] === 1'b1) begin
                    cnt[k]       = delay[k];
                    last_word[k] = spi_data_s[k];
                    if (k == 0) wq0.push_back(spi_data_s[k]);
                    else        wq1.push_back(spi_data_s[k]);
                end else if (k == 0 && inject && was_real) begin
                    // Extra done while the DUT sits in FETCH or a command state
                    spi_done_s[k] = 1'b1;
                end
            end
        end
    end

    function automatic logic [9:0] exp_word(input int i, input int cols, input int pages);
        int per;
        int p;
        int j;
        per = cols + 3;
        p   = (i / per) % pages;
        j   = i % per;
        if (j == 0) return {2'b00, 8'hB0 + 8'(p)};
        if (j == 1) return 10'h000;
        if (j == 2) return 10'h010;
        return {2'b01, 8'(p * cols + j - 3)};
    endfunction

    function automatic logic [9:0] w0(input int i);
        if (i < wq0.size()) return wq0[i];
        return 10'h3FF;
    endfunction

    function automatic logic [9:0] w1(input int i);
        if (i < wq1.size()) return wq1[i];
        return 10'h3FF;
    endfunction

    task automatic pulse_start();
        @(negedge CLK);
        start_s[0] = 1'b1;
        @(negedge CLK);
        start_s[0] = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            if (done_cnt[0] != d0) ok = 1'b1;
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            if (wq0.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        RST_N      = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++;
        if (busy_s[0] !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_s[0]); end
        vectors++;
        if (done_s[0] !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_s[0]); end
        vectors++;
        if (spi_start_s[0] !== 1'b0) begin miscompares++; $display("FAIL reset_spi_start: got %b want 0", spi_start_s[0]); end
        vectors++;
        if (spi_data_s[0] !== 10'h000) begin miscompares++; $display("FAIL reset_spi_data: got 0x%03h want 0x000", spi_data_s[0]); end
        vectors++;
        if (fb_addr_s[0] !== 10'h000) begin miscompares++; $display("FAIL reset_fb_addr: got 0x%03h want 0x000", fb_addr_s[0]); end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_full_frame();
        bit ok;
        int d0;
        int nb0;
        wq0.delete();
        d0  = done_cnt[0];
        nb0 = done_no_busy[0];
        pulse_start();
        wait_done(d0, 20000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL frame_timeout: got no DONE want DONE within budget"); end
        vectors++;
        if (w0(0) !== 10'h0B0) begin miscompares++; $display("FAIL first_word: got 0x%03h want 0x0B0", w0(0)); end
        vectors++;
        if (w0(1) !== 10'h000) begin miscompares++; $display("FAIL second_word: got 0x%03h want 0x000", w0(1)); end
        vectors++;
        if (w0(2) !== 10'h010) begin miscompares++; $display("FAIL third_word: got 0x%03h want 0x010", w0(2)); end
        vectors++;
        if (w0(3)[9:8] !== 2'b01) begin miscompares++; $display("FAIL data_dc: got 0x%03h want 0x1xx", w0(3)); end
        vectors++;
        if (wq0.size() !== 1048) begin miscompares++; $display("FAIL word_count: got %0d want 1048", wq0.size()); end
        vectors++;
        if (done_cnt[0] - d0 !== 1) begin miscompares++; $display("FAIL done_pulses: got %0d want 1", done_cnt[0] - d0); end
        vectors++;
        if (done_no_busy[0] != nb0) begin miscompares++; $display("FAIL busy_at_done: got BUSY low during DONE want high"); end
        vectors++;
        if (busy_s[0] !== 1'b0) begin miscompares++; $display("FAIL busy_after: got %b want 0", busy_s[0]); end
        vectors++;
        if (extra_starts[0] != 0) begin miscompares++; $display("FAIL extra_starts: got %0d want 0", extra_starts[0]); end
    endtask

    task automatic test_frame_content();
        bit ok;
        wq0.delete();
        pulse_start();
        wait_done(done_cnt[0], 20000, ok);
        for (int p = 0; p < 8; p++) begin
            int bad;
            int first;
            bad   = 0;
            first = -1;
            for (int j = 0; j < 131; j++) begin
                if (w0(p * 131 + j) !== exp_word(p * 131 + j, 128, 8)) begin
                    bad++;
                    if (first < 0) first = p * 131 + j;
                end
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL page%0d_content: %0d bad words, word %0d got 0x%03h want 0x%03h",
                         p, bad, first, w0(first), exp_word(first, 128, 8));
            end
        end
    endtask

    task automatic test_restart_ignored();
        bit ok;
        int d0;
        int bad;
        wq0.delete();
        d0     = done_cnt[0];
        inject = 1'b1;
        pulse_start();
        wait_words(200, 5000, ok);
        start_s[0] = 1'b1;
        repeat (50) @(negedge CLK);
        start_s[0] = 1'b0;
        wait_done(d0, 20000, ok);
        inject = 1'b0;
        vectors++;
        if (wq0.size() !== 1048) begin miscompares++; $display("FAIL restart_word_count: got %0d want 1048", wq0.size()); end
        vectors++;
        if (done_cnt[0] - d0 !== 1) begin miscompares++; $display("FAIL restart_done_pulses: got %0d want 1", done_cnt[0] - d0); end
        bad = 0;
        for (int i = 0; i < 1048; i++) if (w0(i) !== exp_word(i, 128, 8)) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL restart_content: got %0d bad words want 0", bad); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int d0;
        wq0.delete();
        d0 = done_cnt[0];
        pulse_start();
        wait_words(500, 10000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL midreset_timeout: got %0d words want 500", wq0.size()); end
        #2;
        RST_N = 1'b0;
        #1;
        vectors++;
        if (busy_s[0] !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy_s[0]); end
        vectors++;
        if (spi_data_s[0] !== 10'h000) begin miscompares++; $display("FAIL midreset_spi_data: got 0x%03h want 0x000", spi_data_s[0]); end
        vectors++;
        if (fb_addr_s[0] !== 10'h000) begin miscompares++; $display("FAIL midreset_fb_addr: got 0x%03h want 0x000", fb_addr_s[0]); end
        vectors++;
        if (spi_start_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_pulses: got start=%b done=%b want 0 0", spi_start_s[0], done_s[0]);
        end
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        vectors++;
        if (done_cnt[0] != d0) begin miscompares++; $display("FAIL midreset_partial_done: got %0d pulses want 0", done_cnt[0] - d0); end
        wq0.delete();
        pulse_start();
        wait_words(1, 50, ok);
        vectors++;
        if (w0(0) !== 10'h0B0) begin miscompares++; $display("FAIL midreset_restart: got 0x%03h want 0x0B0", w0(0)); end
    endtask

    task automatic test_slow_spi();
        bit ok;
        int u0;
        int e0;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        delay[0] = 100;
        u0 = unstable[0];
        e0 = extra_starts[0];
        RST_N = 1'b1;
        wq0.delete();
        pulse_start();
        wait_words(5, 1000, ok);
        repeat (50) @(negedge CLK);
        vectors++;
        if (wq0.size() !== 5) begin miscompares++; $display("FAIL slow_word_count: got %0d want 5", wq0.size()); end
        vectors++;
        if (unstable[0] != u0) begin miscompares++; $display("FAIL slow_data_stable: got %0d changes want 0", unstable[0] - u0); end
        vectors++;
        if (extra_starts[0] != e0) begin miscompares++; $display("FAIL slow_extra_start: got %0d want 0", extra_starts[0] - e0); end
        vectors++;
        if (w0(3) !== 10'h100) begin miscompares++; $display("FAIL slow_first_data: got 0x%03h want 0x100", w0(3)); end
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        delay[0] = 4;
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_continuous();
        bit ok;
        int gaps;
        int bad;
        wq1.delete();
        gaps = 0;
        ok   = 1'b0;
        @(negedge CLK);
        start_s[1] = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge CLK);
            if (wq1.size() >= 1 && busy_s[1] !== 1'b1) gaps++;
            if (wq1.size() >= 15) ok = 1'b1;
        end
        start_s[1] = 1'b0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL cont_timeout: got %0d words want 15", wq1.size()); end
        bad = 0;
        for (int i = 0; i < 14; i++) if (w1(i) !== exp_word(i, 4, 2)) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL cont_content: got %0d bad words want 0", bad); end
        vectors++;
        if (w1(14) !== 10'h0B0) begin miscompares++; $display("FAIL cont_restart_word: got 0x%03h want 0x0B0", w1(14)); end
        vectors++;
        if (done_cnt[1] !== 1) begin miscompares++; $display("FAIL cont_done: got %0d want 1", done_cnt[1]); end
        vectors++;
        if (gaps != 0) begin miscompares++; $display("FAIL cont_busy_gap: got %0d idle cycles want 0", gaps); end
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge CLK);
            if (done_cnt[1] >= 2) ok = 1'b1;
        end
        repeat (3) @(negedge CLK);
        vectors++;
        if (!ok || busy_s[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_stop: got done=%0d busy=%b want 2 and 0", done_cnt[1], busy_s[1]);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_frame_content();
        test_restart_ignored();
        test_reset_mid_frame();
        test_slow_spi();
        test_continuous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
